// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci handshake stream generator:
// FSM state encoding, handshake-mode selectors and default widths.
package fib_pkg;

   localparam int HS_TWO_PHASE  = 0;
   localparam int HS_FOUR_PHASE = 1;

   localparam int DEF_W     = 8;
   localparam int DEF_CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SEND     = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_WAIT_RTZ = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

endpackage

// File: rtl/fibonacci_hs_stream_if.sv
// Output stream of the Fibonacci generator.
//
// Handshake: the producer presents io_Out_Data/io_Out_Last and then raises
// a token by changing io_Out_HS_Req (two-phase: any transition is a token;
// four-phase: a 0->1 edge is a token).  The consumer accepts by making
// io_Out_HS_Ack equal to io_Out_HS_Req (two-phase) or by raising Ack
// (four-phase), after which the producer drops Req and waits for Ack to
// return low.  Data and Last never change while a token is outstanding.
interface fibonacci_hs_stream_if #(
   parameter int W = fib_pkg::DEF_W
);
   logic         io_Out_HS_Req;
   logic         io_Out_HS_Ack;
   logic [W-1:0] io_Out_Data;
   logic         io_Out_Last;

   modport master (
      output io_Out_HS_Req,
      output io_Out_Data,
      output io_Out_Last,
      input  io_Out_HS_Ack
   );

   modport slave (
      input  io_Out_HS_Req,
      input  io_Out_Data,
      input  io_Out_Last,
      output io_Out_HS_Ack
   );
endinterface

// File: rtl/hs_ack_sync.sv
// Synchroniser for the acknowledge coming from asynchronous click-element
// logic.  SYNC_STAGES flops in series; SYNC_STAGES=0 passes Ack straight
// through for consumers already in this clock domain.
module hs_ack_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic ack_in,
   output logic ack_out
);

   generate
      if (SYNC_STAGES == 0) begin : g_bypass
         assign ack_out = ack_in;
      end else begin : g_chain
         logic [SYNC_STAGES-1:0] chain;

         // Shift Ack through the flop chain; cleared by the synchronous reset.
         always_ff @(posedge clock) begin
            if (!reset) begin
               chain <= '0;
            end else begin
               chain[0] <= ack_in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  chain[i] <= chain[i-1];
               end
            end
         end

         assign ack_out = chain[SYNC_STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/fibonacci_hs_stream.sv
// Streams io_Len Fibonacci terms (F0=0, F1=1, ...) over a Req/Ack
// handshake, started by a rising edge on io_Go.  Two- or four-phase
// handshake, and stop-or-wrap policy when a term no longer fits in W bits.
module fibonacci_hs_stream
   import fib_pkg::*;
#(
   parameter int W           = DEF_W,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int FOUR_PHASE  = HS_TWO_PHASE,
   parameter int OVF_WRAP    = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  io_Go,
   input  logic [CNT_W-1:0]      io_Len,
   fibonacci_hs_stream_if.master out_hs,
   output logic                  io_Busy,
   output logic                  io_Done,
   output logic                  io_Overflow,
   output state_t                dbg_state
);

   localparam logic [W-1:0]     TERM_ONE = W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   logic             go_q;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] cnt;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic             b_carry;   // b was produced by an addition that carried
   logic             req_r;
   logic [W-1:0]     data_r;
   logic             last_r;
   logic             ack_s;
   logic             go_rise;
   logic             stopping;
   logic             tok_done;
   logic [W:0]       sum;

   hs_ack_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clock   (clock),
      .reset   (reset),
      .ack_in  (out_hs.io_Out_HS_Ack),
      .ack_out (ack_s)
   );

   assign go_rise  = io_Go & ~go_q;
   assign sum      = {1'b0, a} + {1'b0, b};
   // In stop mode the term after the current one is unrepresentable, so the
   // current token must be the final one.
   assign stopping = (OVF_WRAP == 0) && b_carry;

   // Token completion: two-phase when Ack matches Req, four-phase once Ack
   // has returned to zero after the acknowledge.
   always_comb begin
      tok_done = 1'b0;
      if (FOUR_PHASE == HS_TWO_PHASE) begin
         tok_done = (state == ST_WAIT_ACK) && (ack_s == req_r);
      end else begin
         tok_done = (state == ST_WAIT_RTZ) && !ack_s;
      end
   end

   // Control FSM and datapath; all outputs are registered here.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= ST_IDLE;
         go_q        <= 1'b0;
         len_q       <= '0;
         cnt         <= '0;
         a           <= '0;
         b           <= TERM_ONE;
         b_carry     <= 1'b0;
         req_r       <= 1'b0;
         data_r      <= '0;
         last_r      <= 1'b0;
         io_Busy     <= 1'b0;
         io_Done     <= 1'b0;
         io_Overflow <= 1'b0;
      end else begin
         go_q <= io_Go;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (go_rise) begin
                  io_Overflow <= 1'b0;
                  last_r      <= 1'b0;
                  if (io_Len == '0) begin
                     state   <= ST_DONE;
                     io_Done <= 1'b1;
                  end else begin
                     len_q   <= io_Len;
                     a       <= '0;
                     b       <= TERM_ONE;
                     b_carry <= 1'b0;
                     cnt     <= '0;
                     io_Done <= 1'b0;
                     io_Busy <= 1'b1;
                     state   <= ST_SEND;
                  end
               end
            end
            ST_SEND: begin
               data_r <= a;
               last_r <= (cnt == (len_q - CNT_ONE)) || stopping;
               req_r  <= (FOUR_PHASE == HS_TWO_PHASE) ? ~req_r : 1'b1;
               state  <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if ((FOUR_PHASE != HS_TWO_PHASE) && ack_s) begin
                  req_r <= 1'b0;
                  state <= ST_WAIT_RTZ;
               end
            end
            ST_WAIT_RTZ: begin
               // Completion handled below once Ack has returned low.
            end
            default: state <= ST_IDLE;
         endcase

         if (tok_done) begin
            cnt <= cnt + CNT_ONE;
            if (last_r) begin
               state   <= ST_DONE;
               io_Busy <= 1'b0;
               io_Done <= 1'b1;
               last_r  <= 1'b0;
            end else begin
               a       <= b;
               b       <= sum[W-1:0];
               b_carry <= sum[W];
               if (sum[W]) begin
                  io_Overflow <= 1'b1;
               end
               state <= ST_SEND;
            end
         end
      end
   end

   assign out_hs.io_Out_HS_Req = req_r;
   assign out_hs.io_Out_Data   = data_r;
   assign out_hs.io_Out_Last   = last_r;
   assign dbg_state            = state;

endmodule

// File: tb/tb_fibonacci_hs_stream.sv
// Bench for fibonacci_hs_stream: three instances (two-phase stop, two-phase
// wrap, four-phase stop) sharing clock, reset and Len.
module tb_fibonacci_hs_stream;
   import fib_pkg::*;

   localparam int W     = 8;
   localparam int CNT_W = 8;
   localparam longint LIM = 64'd1 << W;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic [2:0]       go;
   logic [CNT_W-1:0] len;
   logic [2:0]       busy, done, ovf;
   state_t           st0, st1, st2;
   logic             stall0;

   fibonacci_hs_stream_if #(.W(W)) if0 ();
   fibonacci_hs_stream_if #(.W(W)) if1 ();
   fibonacci_hs_stream_if #(.W(W)) if2 ();

   fibonacci_hs_stream #(.W(W), .CNT_W(CNT_W), .FOUR_PHASE(0), .OVF_WRAP(0), .SYNC_STAGES(2)) dut0 (
      .clock(clock), .reset(reset), .io_Go(go[0]), .io_Len(len), .out_hs(if0.master),
      .io_Busy(busy[0]), .io_Done(done[0]), .io_Overflow(ovf[0]), .dbg_state(st0));
   fibonacci_hs_stream #(.W(W), .CNT_W(CNT_W), .FOUR_PHASE(0), .OVF_WRAP(1), .SYNC_STAGES(2)) dut1 (
      .clock(clock), .reset(reset), .io_Go(go[1]), .io_Len(len), .out_hs(if1.master),
      .io_Busy(busy[1]), .io_Done(done[1]), .io_Overflow(ovf[1]), .dbg_state(st1));
   fibonacci_hs_stream #(.W(W), .CNT_W(CNT_W), .FOUR_PHASE(1), .OVF_WRAP(0), .SYNC_STAGES(2)) dut2 (
      .clock(clock), .reset(reset), .io_Go(go[2]), .io_Len(len), .out_hs(if2.master),
      .io_Busy(busy[2]), .io_Done(done[2]), .io_Overflow(ovf[2]), .dbg_state(st2));

   // Two-phase consumers: Ack echoes Req after 5 ns; dut0 can be stalled.
   always @(if0.io_Out_HS_Req or stall0) if (!stall0) if0.io_Out_HS_Ack <= #5 if0.io_Out_HS_Req;
   always @(if1.io_Out_HS_Req) if1.io_Out_HS_Ack <= #5 if1.io_Out_HS_Req;

   // Four-phase consumer: Ack follows Req three cycles later on each edge.
   logic [2:0] d4;
   always @(posedge clock) d4 <= {d4[1:0], if2.io_Out_HS_Req};
   assign if2.io_Out_HS_Ack = d4[2];

   // ---------------- observation mux ----------------
   int           sel = 0;
   logic         req_m, last_m, ack_m, busy_m, done_m, ovf_m;
   logic [W-1:0] data_m;
   state_t       st_m;

   always_comb begin
      req_m = if0.io_Out_HS_Req; last_m = if0.io_Out_Last; ack_m = if0.io_Out_HS_Ack;
      data_m = if0.io_Out_Data; busy_m = busy[0]; done_m = done[0]; ovf_m = ovf[0]; st_m = st0;
      case (sel)
         1: begin
            req_m = if1.io_Out_HS_Req; last_m = if1.io_Out_Last; ack_m = if1.io_Out_HS_Ack;
            data_m = if1.io_Out_Data; busy_m = busy[1]; done_m = done[1]; ovf_m = ovf[1]; st_m = st1;
         end
         2: begin
            req_m = if2.io_Out_HS_Req; last_m = if2.io_Out_Last; ack_m = if2.io_Out_HS_Ack;
            data_m = if2.io_Out_Data; busy_m = busy[2]; done_m = done[2]; ovf_m = ovf[2]; st_m = st2;
         end
         default: ;
      endcase
   end

   // ---------------- scoreboard ----------------
   int         n_cmp = 0;
   int         n_fail = 0;
   logic [W-1:0] exp_q[$];
   logic         exp_last_q[$];

   // Reference Fibonacci sequence with stop-or-wrap at 2^W.
   task automatic push_expected(input int n, input bit wrap);
      longint fa, fb, t;
      fa = 0; fb = 1;
      for (int i = 0; i < n; i++) begin
         if (!wrap && fa >= LIM) break;
         exp_q.push_back(fa[W-1:0]);
         exp_last_q.push_back((i == n - 1) || (!wrap && fb >= LIM));
         t = fa + fb; fa = fb; fb = t;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic start_run(input int s, input int n);
      @(negedge clock);
      go[s] = 1'b0;
      @(negedge clock);
      len   = n[CNT_W-1:0];
      go[s] = 1'b1;
   endtask

   // Watches the selected DUT until Done, popping the scoreboard per token.
   task automatic collect(input int budget, input bit toggle, input logic prev_init, output int ntok);
      logic         prev;
      logic         tok;
      logic [W-1:0] e;
      logic         el;
      int           cyc;
      bit           fin;
      prev = prev_init; cyc = 0; fin = 0; ntok = 0;
      while (!fin && cyc < budget) begin
         @(negedge clock);
         cyc++;
         tok = (sel == 2) ? (req_m && !prev) : (req_m != prev);
         if (tok) begin
            ntok++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL extra_token: got data=%0d last=%0d, required no token", data_m, last_m);
            end else begin
               e  = exp_q.pop_front();
               el = exp_last_q.pop_front();
               if (data_m !== e || last_m !== el) begin
                  n_fail++;
                  $display("FAIL token_%0d: got data=%0d last=%0d, required data=%0d last=%0d",
                           ntok, data_m, last_m, e, el);
               end
            end
            if (sel == 2) begin
               n_cmp++;
               if (ack_m !== 1'b0) begin
                  n_fail++;
                  $display("FAIL rise_before_rtz: got ack=%0d at Req rise, required 0", ack_m);
               end
            end
         end
         prev = req_m;
         if (toggle && st_m == ST_SEND) go[sel] = ~go[sel];
         if (done_m && !busy_m) fin = 1;
      end
      if (!fin) begin
         n_cmp++; n_fail++;
         $display("FAIL collect_timeout: no Done within %0d cycles", budget);
      end
      repeat (6) @(negedge clock);
      n_cmp++;
      if (req_m !== prev) begin
         n_fail++;
         $display("FAIL req_after_done: got req=%0d, required %0d", req_m, prev);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0; go = '0; len = '0; stall0 = 1'b0; sel = 0;
      repeat (6) @(negedge clock);
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         n_cmp++;
         if ({req_m, last_m, busy_m, done_m, ovf_m} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags_%0d: got req/last/busy/done/ovf=%b, required 00000", s,
                     {req_m, last_m, busy_m, done_m, ovf_m});
         end
         n_cmp++;
         if (data_m !== '0) begin
            n_fail++; $display("FAIL reset_data_%0d: got %0d, required 0", s, data_m);
         end
         n_cmp++;
         if (st_m !== ST_IDLE) begin
            n_fail++; $display("FAIL reset_state_%0d: got %0d, required %0d", s, st_m, ST_IDLE);
         end
      end
      sel = 0;
      reset = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_len0();
      logic prev;
      sel = 0; #1;
      prev = req_m;
      @(negedge clock);
      len = '0; go[0] = 1'b1;
      repeat (2) @(negedge clock);
      n_cmp++;
      if (done_m !== 1'b1 || busy_m !== 1'b0 || st_m !== ST_DONE) begin
         n_fail++;
         $display("FAIL len0_done: got done=%0d busy=%0d state=%0d, required 1 0 %0d", done_m, busy_m, st_m, ST_DONE);
      end
      repeat (8) @(negedge clock);
      n_cmp++;
      if (req_m !== prev) begin
         n_fail++; $display("FAIL len0_req: got %0d, required %0d", req_m, prev);
      end
      go[0] = 1'b0;
   endtask

   task automatic test_two_phase_basic();
      logic prev;
      int   ntok;
      sel = 0; #1;
      push_expected(13, 0);
      prev = req_m;
      start_run(0, 13);
      @(negedge clock);
      n_cmp++;
      if (req_m !== prev) begin
         n_fail++; $display("FAIL latency_early: got req=%0d one edge after Go, required %0d", req_m, prev);
      end
      @(negedge clock);
      n_cmp++;
      if (req_m !== ~prev) begin
         n_fail++; $display("FAIL latency_req: got req=%0d two edges after Go, required %0d", req_m, ~prev);
      end
      len = 8'd3;
      collect(600, 0, prev, ntok);
      n_cmp++;
      if (ntok !== 13) begin n_fail++; $display("FAIL basic_tokens: got %0d, required 13", ntok); end
      n_cmp++;
      if (done_m !== 1'b1 || ovf_m !== 1'b0 || last_m !== 1'b0 || data_m !== 8'd144) begin
         n_fail++;
         $display("FAIL basic_end: got done=%0d ovf=%0d last=%0d data=%0d, required 1 0 0 144", done_m, ovf_m, last_m, data_m);
      end
      n_cmp++;
      if (exp_q.size() !== 0) begin n_fail++; $display("FAIL basic_left: got %0d unseen, required 0", exp_q.size()); end
   endtask

   task automatic test_overflow_stop();
      logic prev;
      int   ntok;
      sel = 0; #1;
      push_expected(20, 0);
      prev = req_m;
      start_run(0, 20);
      collect(800, 0, prev, ntok);
      n_cmp++;
      if (ntok !== 14) begin n_fail++; $display("FAIL stop_tokens: got %0d, required 14", ntok); end
      n_cmp++;
      if (ovf_m !== 1'b1 || done_m !== 1'b1 || data_m !== 8'd233) begin
         n_fail++;
         $display("FAIL stop_end: got ovf=%0d done=%0d data=%0d, required 1 1 233", ovf_m, done_m, data_m);
      end
      n_cmp++;
      if (exp_q.size() !== 0) begin n_fail++; $display("FAIL stop_left: got %0d unseen, required 0", exp_q.size()); end
   endtask

   task automatic test_overflow_wrap();
      logic prev;
      int   ntok;
      sel = 1; #1;
      push_expected(16, 1);
      prev = req_m;
      start_run(1, 16);
      collect(800, 0, prev, ntok);
      n_cmp++;
      if (ntok !== 16) begin n_fail++; $display("FAIL wrap_tokens: got %0d, required 16", ntok); end
      n_cmp++;
      if (ovf_m !== 1'b1 || done_m !== 1'b1 || data_m !== 8'd98) begin
         n_fail++;
         $display("FAIL wrap_end: got ovf=%0d done=%0d data=%0d, required 1 1 98", ovf_m, done_m, data_m);
      end
      go[1] = 1'b0;
   endtask

   task automatic test_four_phase();
      logic prev;
      int   ntok;
      sel = 2; #1;
      push_expected(4, 0);
      prev = req_m;
      start_run(2, 4);
      collect(600, 0, prev, ntok);
      n_cmp++;
      if (ntok !== 4) begin n_fail++; $display("FAIL fp_tokens: got %0d, required 4", ntok); end
      n_cmp++;
      if (req_m !== 1'b0 || ovf_m !== 1'b0 || done_m !== 1'b1 || data_m !== 8'd2) begin
         n_fail++;
         $display("FAIL fp_end: got req=%0d ovf=%0d done=%0d data=%0d, required 0 0 1 2", req_m, ovf_m, done_m, data_m);
      end
      go[2] = 1'b0;
   endtask

   task automatic test_len1_and_go_held();
      logic prev;
      int   ntok;
      sel = 0; #1;
      push_expected(1, 0);
      prev = req_m;
      start_run(0, 1);
      collect(300, 0, prev, ntok);
      n_cmp++;
      if (ntok !== 1) begin n_fail++; $display("FAIL len1_tokens: got %0d, required 1", ntok); end
      prev = req_m;
      repeat (20) @(negedge clock);
      n_cmp++;
      if (busy_m !== 1'b0 || st_m !== ST_DONE || req_m !== prev) begin
         n_fail++;
         $display("FAIL go_held: got busy=%0d state=%0d req=%0d, required 0 %0d %0d", busy_m, st_m, req_m, ST_DONE, prev);
      end
   endtask

   task automatic test_go_toggle_busy();
      logic prev;
      int   ntok;
      sel = 0; #1;
      push_expected(10, 0);
      prev = req_m;
      start_run(0, 10);
      collect(600, 1, prev, ntok);
      n_cmp++;
      if (ntok !== 10) begin n_fail++; $display("FAIL toggle_tokens: got %0d, required 10", ntok); end
      go[0] = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic prev;
      int   ntok;
      int   cyc;
      sel = 0; #1;
      stall0 = 1'b1;
      start_run(0, 5);
      cyc = 0;
      while (st_m != ST_WAIT_ACK && cyc < 50) begin @(negedge clock); cyc++; end
      n_cmp++;
      if (st_m !== ST_WAIT_ACK) begin
         n_fail++; $display("FAIL mid_wait: got state=%0d, required %0d", st_m, ST_WAIT_ACK);
      end
      repeat (3) @(negedge clock);
      reset = 1'b0; stall0 = 1'b0;
      @(negedge clock);
      n_cmp++;
      if ({req_m, last_m, busy_m, done_m, ovf_m} !== 5'b0 || data_m !== '0 || st_m !== ST_IDLE) begin
         n_fail++;
         $display("FAIL mid_reset: got req/last/busy/done/ovf=%b data=%0d state=%0d, required 00000 0 %0d",
                  {req_m, last_m, busy_m, done_m, ovf_m}, data_m, st_m, ST_IDLE);
      end
      go[0] = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      push_expected(3, 0);
      prev = req_m;
      start_run(0, 3);
      collect(300, 0, prev, ntok);
      n_cmp++;
      if (ntok !== 3) begin n_fail++; $display("FAIL restart_tokens: got %0d, required 3", ntok); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_len0();
      test_two_phase_basic();
      test_overflow_stop();
      test_overflow_wrap();
      test_four_phase();
      test_len1_and_go_held();
      test_go_toggle_busy();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
